// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-SRAM load/store issue, load alignment, exception resolve
module mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        es_to_ms_valid,
  output logic        ms_allow_in,
  input  logic [31:0] es_pc,
  input  logic [3:0]  es_mem_op,
  input  logic [31:0] es_addr,
  input  logic [31:0] es_wdata,
  input  logic [3:0]  es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic [31:0] es_rf_wdata,
  input  logic [7:0]  es_excp,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        ws_allow_in,
  output logic        ms_to_ws_valid,
  output logic        ms_valid,
  output logic [31:0] ms_pc,
  output logic [3:0]  ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic [31:0] ms_rf_wdata,
  output logic        ms_excp,
  output logic [5:0]  ms_ecode,
  output logic        ms_ertn
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d, cancel_q, cancel_d;
  logic [31:0] pc_q, addr_q, wdata_q, rf_wdata_q, rdata_q, rdata_d;
  logic [3:0]  op_q, rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [7:0]  excp_q;
  logic        ready_go, accept, handoff, start;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ready_go       = (state_q == IDLE) || (state_q == DONE);
  assign ms_to_ws_valid = valid_q && ready_go;
  assign ms_allow_in    = !cancel_q && (!valid_q || (ready_go && ws_allow_in));
  assign accept         = es_to_ms_valid && ms_allow_in && !flush;
  assign handoff        = ms_to_ws_valid && ws_allow_in;
  assign start          = accept && (es_mem_op != 4'b0000) && (es_excp == 8'h00);

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    if (flush)        valid_d = 1'b0;
    else if (accept)  valid_d = 1'b1;
    else if (handoff) valid_d = 1'b0;
    else              valid_d = valid_q;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      // An address accepted in the flush cycle still owes a response that must be swallowed.
      REQ: begin
        if (data_addr_ok) begin
          state_d = WAIT;
          if (flush) cancel_d = 1'b1;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          cancel_d = 1'b0;
          if (flush || cancel_q) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            rdata_d = data_rdata;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      DONE: begin
        if (flush)        state_d = IDLE;
        else if (handoff) state_d = start ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      cancel_q   <= 1'b0;
      rdata_q    <= '0;
      pc_q       <= RESET_PC;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rf_we_q    <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      excp_q     <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
      if (accept) begin
        pc_q       <= es_pc;
        op_q       <= es_mem_op;
        addr_q     <= es_addr;
        wdata_q    <= es_wdata;
        rf_we_q    <= es_rf_we;
        rf_waddr_q <= es_rf_waddr;
        rf_wdata_q <= es_rf_wdata;
        excp_q     <= es_excp;
      end
    end
  end

  assign data_req  = (state_q == REQ);
  assign data_wr   = (op_q[3:2] == 2'b01);
  assign data_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = wdata_q;
    if (data_wr) begin
      case (op_q[1:0])
        2'b00: begin
          data_wstrb = 4'b0001 << addr_q[1:0];
          data_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{wdata_q[15:0]}};
        end
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = rdata_q[7:0];
      2'b01:   ld_byte = rdata_q[15:8];
      2'b10:   ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      4'b1000: ms_rf_wdata = {{24{ld_byte[7]}}, ld_byte};
      4'b1100: ms_rf_wdata = {24'h000000, ld_byte};
      4'b1001: ms_rf_wdata = {{16{ld_half[15]}}, ld_half};
      4'b1101: ms_rf_wdata = {16'h0000, ld_half};
      4'b1010: ms_rf_wdata = rdata_q;
      default: ms_rf_wdata = rf_wdata_q;
    endcase
  end

  always_comb begin
    ms_ecode = 6'h00;
    if      (excp_q[6]) ms_ecode = 6'h00;
    else if (excp_q[5]) ms_ecode = 6'h08;
    else if (excp_q[4]) ms_ecode = 6'h0D;
    else if (excp_q[3]) ms_ecode = 6'h0E;
    else if (excp_q[2]) ms_ecode = 6'h0B;
    else if (excp_q[1]) ms_ecode = 6'h0C;
    else if (excp_q[0]) ms_ecode = 6'h09;
  end

  assign ms_valid    = valid_q;
  assign ms_pc       = valid_q ? pc_q : RESET_PC;
  assign ms_excp     = valid_q && (|excp_q[6:0]);
  assign ms_ertn     = valid_q && excp_q[7] && !ms_excp;
  assign ms_rf_we    = (valid_q && !ms_excp) ? rf_we_q : 4'b0000;
  assign ms_rf_waddr = rf_waddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized + directed bench for mem_stage against a transaction-level model
module tb_mem_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk, reset, flush, es_to_ms_valid, ms_allow_in;
  logic [31:0] es_pc, es_addr, es_wdata, es_rf_wdata;
  logic [3:0]  es_mem_op, es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [7:0]  es_excp;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        ws_allow_in, ms_to_ws_valid, ms_valid, ms_excp, ms_ertn;
  logic [31:0] ms_pc, ms_rf_wdata;
  logic [3:0]  ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [5:0]  ms_ecode;

  mem_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .es_to_ms_valid(es_to_ms_valid),
    .ms_allow_in(ms_allow_in), .es_pc(es_pc), .es_mem_op(es_mem_op), .es_addr(es_addr),
    .es_wdata(es_wdata), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .es_rf_wdata(es_rf_wdata), .es_excp(es_excp), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ws_allow_in(ws_allow_in), .ms_to_ws_valid(ms_to_ws_valid), .ms_valid(ms_valid),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_excp(ms_excp), .ms_ecode(ms_ecode), .ms_ertn(ms_ertn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, addr, wdata, wd;
    logic [3:0]  op, we;
    logic [4:0]  wa;
    logic [7:0]  ex;
  } instr_t;

  int total = 0;
  int bad = 0;

  // Model: the instruction MEM holds, whether its bus request went out, whether data came back,
  // and whether any accepted bus request is still waiting for its response.
  instr_t      cur;
  bit          have = 0, issued = 0, got = 0, outstanding = 0;
  logic [31:0] ldval = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit needbus(input instr_t i);
    return (i.op != 4'b0000) && (i.ex == 8'h00);
  endfunction

  function automatic logic [5:0] ecode_of(input logic [7:0] ex);
    if (ex[6]) return 6'h00;
    if (ex[5]) return 6'h08;
    if (ex[4]) return 6'h0D;
    if (ex[3]) return 6'h0E;
    if (ex[2]) return 6'h0B;
    if (ex[1]) return 6'h0C;
    return 6'h09;
  endfunction

  function automatic logic [31:0] ld_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(a[1:0]))) & 32'hff;
    h = (rd >> (16 * int'(a[1]))) & 32'hffff;
    case (op)
      4'b1000: return (b ^ 32'h80) - 32'h80;
      4'b1100: return b;
      4'b1001: return (h ^ 32'h8000) - 32'h8000;
      4'b1101: return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic [3:0] op, input logic [31:0] a);
    case (op)
      4'b0100: return 4'b0001 << a[1:0];
      4'b0101: return 4'b0011 << {a[1], 1'b0};
      4'b0110: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_bus_wdata(input logic [3:0] op, input logic [31:0] w);
    case (op)
      4'b0100: return {24'h0, w[7:0]} * 32'h01010101;
      4'b0101: return {16'h0, w[15:0]} * 32'h00010001;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    bit exp_ready, exp_req, exp_allow, exc, acc, hand, aok, dok;
    if (reset) begin
      have = 0; issued = 0; got = 0; outstanding = 0;
    end else begin
      exp_ready = have && (!needbus(cur) || got);
      exp_req   = have && needbus(cur) && !issued;
      exp_allow = !outstanding && (!have || (exp_ready && ws_allow_in));
      check("ms_valid", 32'(ms_valid), 32'(have));
      check("ms_to_ws_valid", 32'(ms_to_ws_valid), 32'(exp_ready));
      check("ms_allow_in", 32'(ms_allow_in), 32'(exp_allow));
      check("data_req", 32'(data_req), 32'(exp_req));
      if (have) begin
        exc = |cur.ex[6:0];
        check("ms_pc", ms_pc, cur.pc);
        check("ms_excp", 32'(ms_excp), 32'(exc));
        if (exc) check("ms_ecode", 32'(ms_ecode), 32'(ecode_of(cur.ex)));
        check("ms_ertn", 32'(ms_ertn), 32'(cur.ex[7] && !exc));
        check("ms_rf_we", 32'(ms_rf_we), exc ? 32'h0 : 32'(cur.we));
        check("ms_rf_waddr", 32'(ms_rf_waddr), 32'(cur.wa));
        if (exp_ready && !cur.op[3]) check("ms_rf_wdata", ms_rf_wdata, cur.wd);
        if (exp_ready && cur.op[3] && needbus(cur))
          check("ms_rf_wdata_ld", ms_rf_wdata, ld_result(cur.op, cur.addr, ldval));
        if (exp_req) begin
          check("data_addr", data_addr, {cur.addr[31:2], 2'b00});
          check("data_wr", 32'(data_wr), 32'(cur.op[3:2] == 2'b01));
          check("data_wstrb", 32'(data_wstrb), 32'(exp_strb(cur.op, cur.addr)));
          if (cur.op[3:2] == 2'b01)
            check("data_wdata", data_wdata, exp_bus_wdata(cur.op, cur.wdata));
        end
      end else begin
        check("ms_pc_idle", ms_pc, RESET_PC);
        check("ms_rf_we_idle", 32'(ms_rf_we), 32'h0);
        check("ms_excp_idle", 32'(ms_excp), 32'h0);
        check("ms_ertn_idle", 32'(ms_ertn), 32'h0);
      end
      acc  = es_to_ms_valid && exp_allow && !flush;
      hand = exp_ready && ws_allow_in;
      aok  = exp_req && data_addr_ok;
      dok  = outstanding && data_data_ok;
      if (dok) begin
        outstanding = 0;
        if (have) begin got = 1; ldval = data_rdata; end
      end
      if (aok) begin outstanding = 1; issued = 1; end
      if (flush || hand) have = 0;
      if (acc) begin
        have = 1; issued = 0; got = 0;
        cur.pc = es_pc; cur.op = es_mem_op; cur.addr = es_addr; cur.wdata = es_wdata;
        cur.we = es_rf_we; cur.wa = es_rf_waddr; cur.wd = es_rf_wdata; cur.ex = es_excp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w, input logic [7:0] ex);
    es_pc = 32'h1c000100 + {20'h0, a[11:0]}; es_mem_op = op; es_addr = a; es_wdata = w;
    es_rf_we = 4'hf; es_rf_waddr = 5'd7; es_rf_wdata = 32'h55aa0000; es_excp = ex;
  endtask

  task automatic rand_instr();
    logic [3:0] ops [9] = '{4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b0100, 4'b0101, 4'b0110};
    logic [3:0] op;
    logic [31:0] a;
    logic [7:0] ex;
    int k;
    op = ops[$urandom_range(0, 8)];
    a = $urandom;
    ex = 8'h00;
    if (op != 4'b0000 && ((op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b10 && a[1:0] != 2'b00)))
      ex[0] = 1'b1;
    if ($urandom_range(0, 7) == 0) begin
      k = $urandom_range(1, 7);
      ex[k] = 1'b1;
    end
    es_pc = $urandom; es_mem_op = op; es_addr = a; es_wdata = $urandom;
    es_rf_we = 4'($urandom); es_rf_waddr = 5'($urandom); es_rf_wdata = $urandom; es_excp = ex;
  endtask

  // Load/store whose bus answers in the earliest possible cycles; checks issue fields and result.
  task automatic mem_min(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] rd, input logic [3:0] strb, input logic [31:0] bus_wd,
                         input logic [31:0] res);
    set_instr(op, a, w, 8'h00);
    es_to_ms_valid = 1; ws_allow_in = 1; data_addr_ok = 1;
    tick();
    es_to_ms_valid = 0;
    check({nm, "_req"}, 32'(data_req), 32'h1);
    check({nm, "_addr"}, data_addr, {a[31:2], 2'b00});
    check({nm, "_wr"}, 32'(data_wr), 32'(strb != 4'b0000));
    check({nm, "_strb"}, 32'(data_wstrb), 32'(strb));
    if (strb != 4'b0000) check({nm, "_wdata"}, data_wdata, bus_wd);
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
    check({nm, "_notready"}, 32'(ms_to_ws_valid), 32'h0);
    tick();
    data_data_ok = 0;
    check({nm, "_ready"}, 32'(ms_to_ws_valid), 32'h1);
    check({nm, "_result"}, ms_rf_wdata, res);
    tick();
  endtask

  task automatic rand_cycle(input bit drain);
    es_to_ms_valid = !drain && ($urandom_range(0, 9) < 7);
    rand_instr();
    flush = !drain && ($urandom_range(0, 29) == 0);
    ws_allow_in = drain || ($urandom_range(0, 3) != 0);
    data_addr_ok = drain || ($urandom_range(0, 1) == 1);
    data_data_ok = outstanding && (drain || $urandom_range(0, 2) == 0);
    data_rdata = $urandom;
    tick();
  endtask

  initial begin
    clk = 0; reset = 1; flush = 0; es_to_ms_valid = 0; ws_allow_in = 1;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
    set_instr(4'b0000, 32'h0, 32'h0, 8'h00);
    #1;
    check("rst_valid", 32'(ms_valid), 32'h0);
    check("rst_req", 32'(data_req), 32'h0);
    check("rst_pc", ms_pc, RESET_PC);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("rst_allow", 32'(ms_allow_in), 32'h1);

    mem_min("ldw", 4'b1010, 32'h1c000104, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h0, 32'hDEADBEEF);
    mem_min("ldb", 4'b1000, 32'h1c000203, 32'h0, 32'h80FF0000, 4'b0000, 32'h0, 32'hFFFFFF80);
    mem_min("ldbu", 4'b1100, 32'h1c000203, 32'h0, 32'h80FF0000, 4'b0000, 32'h0, 32'h00000080);
    mem_min("sth", 4'b0101, 32'h1c000302, 32'h00001234, 32'h0, 4'b1100, 32'h12341234, 32'h55aa0000);

    set_instr(4'b0101, 32'h1c000303, 32'h1234, 8'h01);
    es_to_ms_valid = 1;
    tick();
    es_to_ms_valid = 0;
    check("ale_req", 32'(data_req), 32'h0);
    check("ale_excp", 32'(ms_excp), 32'h1);
    check("ale_ecode", 32'(ms_ecode), 32'h09);
    check("ale_rf_we", 32'(ms_rf_we), 32'h0);
    tick();

    set_instr(4'b1010, 32'h1c000400, 32'h0, 8'h00);
    es_to_ms_valid = 1; data_addr_ok = 1;
    tick();
    es_to_ms_valid = 0;
    tick();
    data_addr_ok = 0; flush = 1;
    tick();
    flush = 0; es_to_ms_valid = 1;
    check("fl_valid", 32'(ms_valid), 32'h0);
    check("fl_allow0", 32'(ms_allow_in), 32'h0);
    tick();
    check("fl_allow1", 32'(ms_allow_in), 32'h0);
    tick();
    data_data_ok = 1; data_rdata = 32'h0BADF00D;
    check("fl_allow2", 32'(ms_allow_in), 32'h0);
    check("fl_tows", 32'(ms_to_ws_valid), 32'h0);
    tick();
    data_data_ok = 0; es_to_ms_valid = 0;
    check("fl_allow_after", 32'(ms_allow_in), 32'h1);
    check("fl_valid_after", 32'(ms_valid), 32'h0);
    check("fl_tows_after", 32'(ms_to_ws_valid), 32'h0);

    set_instr(4'b1101, 32'h1c000502, 32'h0, 8'h00);
    es_to_ms_valid = 1; data_addr_ok = 1;
    tick();
    es_to_ms_valid = 0;
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hBEEF1234; ws_allow_in = 0;
    tick();
    data_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      check("hold_tows", 32'(ms_to_ws_valid), 32'h1);
      check("hold_allow", 32'(ms_allow_in), 32'h0);
      check("hold_data", ms_rf_wdata, 32'h0000BEEF);
      tick();
    end
    ws_allow_in = 1;
    tick();

    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 20; c++) rand_cycle(1'b1);
    data_addr_ok = 0; data_data_ok = 0; es_to_ms_valid = 0; ws_allow_in = 1; flush = 0;
    tick();

    set_instr(4'b1010, 32'h1c000600, 32'h0, 8'h00);
    es_to_ms_valid = 1; data_addr_ok = 1;
    tick();
    es_to_ms_valid = 0;
    tick();
    data_addr_ok = 0;
    check("rw_valid_before", 32'(ms_valid), 32'h1);
    reset = 1;
    #1;
    check("rw_valid", 32'(ms_valid), 32'h0);
    check("rw_req", 32'(data_req), 32'h0);
    check("rw_pc", ms_pc, RESET_PC);
    tick();
    reset = 0;
    tick();
    check("rw_allow", 32'(ms_allow_in), 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
